// File: rtl/sdram_param_pkg.sv
// Shared SDRAM parameters: burst lengths plus the data-stage and stream-bridge FSM encodings.
package sdram_param;

  localparam int W_BL   = 4;
  localparam int R_BL   = 4;
  localparam int ADDR_W = 24;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ACT  = 2'd1,
    DS_RW   = 2'd2,
    DS_PRE  = 2'd3
  } ds_state_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_PACK = 3'd1,
    WR_PUSH = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RD_LO   = 3'd5,
    RD_HI   = 3'd6,
    DONE    = 3'd7
  } br_state_e;

  // Low byte-address bits that must be zero for a burst-aligned transfer.
  function automatic logic [ADDR_W-1:0] align_mask(input int bl);
    return ADDR_W'(2 * bl - 1);
  endfunction

endpackage

// File: rtl/sdram_stream_bridge.sv
// Byte stream <-> 16-bit SDRAM word bridge with inline packer/unpacker.
// Optional: SDRAM_BRIDGE_ALIGN_CHK_EN rejects misaligned commands with an err pulse.
module sdram_stream_bridge
  import sdram_param::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [23:0] cmd_addr,
  input  logic [7:0]  cmd_nburst,
  input  logic [7:0]  wb_data,
  input  logic        wb_valid,
  output logic        wb_ready,
  output logic [7:0]  rb_data,
  output logic        rb_valid,
  input  logic        rb_ready,
  output logic [15:0] wr_data,
  output logic [31:0] wr_addr,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [23:0] rd_addr,
  output logic        rd_avalid,
  input  logic        rd_aready,
  input  logic [15:0] rd_data,
  input  logic        rd_valid,
  output logic        rd_ready,
  output logic        busy,
  output logic        err
);

  br_state_e   state_q, state_d;
  logic [23:0] base_q, base_d;
  logic [7:0]  nburst_q, nburst_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [7:0]  burst_idx_q, burst_idx_d;
  logic [7:0]  beat_q, beat_d;
  logic [15:0] word_q, word_d;
  logic        byte_hi_q, byte_hi_d;
  logic [23:0] cmd_mask;
  logic [15:0] total_words;

  assign cmd_mask    = cmd_wr ? align_mask(W_BL) : align_mask(R_BL);
  assign total_words = 16'(nburst_q) * 16'(W_BL);

  assign wr_data = word_q;
  assign wr_addr = {8'd0, base_q + (24'(word_idx_q) << 1)};
  assign rd_addr = (base_q >> 1) + 24'(burst_idx_q) * 24'(R_BL);
  assign rb_data = (state_q == RD_HI) ? word_q[15:8] : word_q[7:0];
  assign busy    = (state_q != IDLE);

`ifdef SDRAM_BRIDGE_ALIGN_CHK_EN
  logic err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    nburst_d    = nburst_q;
    word_idx_d  = word_idx_q;
    burst_idx_d = burst_idx_q;
    beat_d      = beat_q;
    word_d      = word_q;
    byte_hi_d   = byte_hi_q;
`ifdef SDRAM_BRIDGE_ALIGN_CHK_EN
    err_d       = 1'b0;
`endif
    cmd_ready   = 1'b0;
    wb_ready    = 1'b0;
    wr_valid    = 1'b0;
    rd_avalid   = 1'b0;
    rd_ready    = 1'b0;
    rb_valid    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          nburst_d    = cmd_nburst;
          word_idx_d  = '0;
          burst_idx_d = '0;
          beat_d      = '0;
          byte_hi_d   = 1'b0;
          word_d      = '0;
`ifdef SDRAM_BRIDGE_ALIGN_CHK_EN
          base_d = cmd_addr;
          if (|(cmd_addr & cmd_mask)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (cmd_nburst == 8'd0) begin
            state_d = DONE;
          end else begin
            state_d = cmd_wr ? WR_PACK : RD_ADDR;
          end
`else
          base_d = cmd_addr & ~cmd_mask;
          if (cmd_nburst == 8'd0) state_d = DONE;
          else                    state_d = cmd_wr ? WR_PACK : RD_ADDR;
`endif
        end
      end
      WR_PACK: begin
        wb_ready = 1'b1;
        if (wb_valid) begin
          // Little-endian: first byte is the low half of the word.
          if (!byte_hi_q) begin
            word_d[7:0] = wb_data;
            byte_hi_d   = 1'b1;
          end else begin
            word_d[15:8] = wb_data;
            byte_hi_d    = 1'b0;
            state_d      = WR_PUSH;
          end
        end
      end
      WR_PUSH: begin
        wr_valid = 1'b1;
        if (wr_ready) begin
          word_idx_d = word_idx_q + 16'd1;
          state_d    = (word_idx_q == total_words - 16'd1) ? DONE : WR_PACK;
        end
      end
      RD_ADDR: begin
        rd_avalid = 1'b1;
        if (rd_aready) begin
          beat_d  = '0;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        rd_ready = 1'b1;
        if (rd_valid) begin
          word_d  = rd_data;
          state_d = RD_LO;
        end
      end
      RD_LO: begin
        rb_valid = 1'b1;
        if (rb_ready) state_d = RD_HI;
      end
      RD_HI: begin
        rb_valid = 1'b1;
        if (rb_ready) begin
          if (beat_q != 8'(R_BL - 1)) begin
            beat_d  = beat_q + 8'd1;
            state_d = RD_DATA;
          end else if (burst_idx_q != nburst_q - 8'd1) begin
            burst_idx_d = burst_idx_q + 8'd1;
            state_d     = RD_ADDR;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      nburst_q    <= '0;
      word_idx_q  <= '0;
      burst_idx_q <= '0;
      beat_q      <= '0;
      word_q      <= '0;
      byte_hi_q   <= 1'b0;
`ifdef SDRAM_BRIDGE_ALIGN_CHK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      nburst_q    <= nburst_d;
      word_idx_q  <= word_idx_d;
      burst_idx_q <= burst_idx_d;
      beat_q      <= beat_d;
      word_q      <= word_d;
      byte_hi_q   <= byte_hi_d;
`ifdef SDRAM_BRIDGE_ALIGN_CHK_EN
      err_q       <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_sdram_stream_bridge.sv
// Directed bench for sdram_stream_bridge: transaction-level scoreboard plus literal pins.
module tb_sdram_stream_bridge;
  import sdram_param::*;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [23:0] cmd_addr;
  logic [7:0]  cmd_nburst;
  logic [7:0]  wb_data;
  logic        wb_valid, wb_ready;
  logic [7:0]  rb_data;
  logic        rb_valid, rb_ready;
  logic [15:0] wr_data;
  logic [31:0] wr_addr;
  logic        wr_valid, wr_ready;
  logic [23:0] rd_addr;
  logic        rd_avalid, rd_aready;
  logic [15:0] rd_data;
  logic        rd_valid, rd_ready;
  logic        busy, err;

  sdram_stream_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_nburst(cmd_nburst),
    .wb_data(wb_data), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .rb_data(rb_data), .rb_valid(rb_valid), .rb_ready(rb_ready),
    .wr_data(wr_data), .wr_addr(wr_addr), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_addr(rd_addr), .rd_avalid(rd_avalid), .rd_aready(rd_aready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .err(err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [15:0] data;
  } wr_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  wr_t         exp_wr[$];
  logic [23:0] exp_ra[$];
  logic [7:0]  exp_rb[$];
  logic [31:0] log_wa[$];
  logic [15:0] log_wd[$];
  logic [23:0] log_ra[$];
  logic [7:0]  log_rb[$];
  logic [15:0] resp_q[$];
  logic [7:0]  wbytes[0:63];
  int          rb_cnt = 0, err_cnt = 0, busy_cyc = 0, traffic_cnt = 0;
  int          last_rb_cyc = 0, busy_fall_cyc = 0;
  logic        busy_prev = 1'b0;
  logic        hold_pend = 1'b0;
  logic [15:0] hold_d;
  logic [31:0] hold_a;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Backing store the bench's SDRAM answers from: one 16-bit word per word address.
  function automatic logic [15:0] mem_word(input logic [23:0] a);
    return {a[7:0] + 8'h80, a[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected SDRAM traffic and byte stream for one command, derived from the burst rules.
  task automatic model_cmd(input bit wr, input logic [23:0] a, input int nb);
    logic [23:0] base, ra;
    logic [15:0] w;
    base = a - 24'(a % 24'(2 * (wr ? W_BL : R_BL)));
`ifdef SDRAM_BRIDGE_ALIGN_CHK_EN
    if (base != a) return;
`endif
    if (wr) begin
      for (int i = 0; i < nb * W_BL; i++)
        exp_wr.push_back('{{8'd0, 24'(base + 24'(2 * i))}, {wbytes[2*i+1], wbytes[2*i]}});
    end else begin
      for (int b = 0; b < nb; b++) begin
        ra = (base / 2) + 24'(b * R_BL);
        exp_ra.push_back(ra);
        for (int k = 0; k < R_BL; k++) begin
          w = mem_word(ra + 24'(k));
          exp_rb.push_back(w[7:0]);
          exp_rb.push_back(w[15:8]);
        end
      end
    end
  endtask

  // Scoreboard: compare every handshake against the model, track timing facts.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (hold_pend && wr_valid) begin
          chk("wr_hold_data", wr_data, hold_d);
          chk("wr_hold_addr", wr_addr, hold_a);
        end
        hold_pend = wr_valid && !wr_ready;
        hold_d = wr_data;
        hold_a = wr_addr;
        if (wr_valid || rd_avalid) traffic_cnt++;
        if (rb_valid && rd_ready) chk("rd_ready_while_unpacking", rd_ready, 0);
        if (wr_valid && wr_ready) begin
          log_wa.push_back(wr_addr);
          log_wd.push_back(wr_data);
          if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
          else begin
            e = exp_wr.pop_front();
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wr_data, e.data);
          end
        end
        if (rd_avalid && rd_aready) begin
          log_ra.push_back(rd_addr);
          if (exp_ra.size() == 0) chk("rd_unexpected", 1, 0);
          else chk("rd_addr", rd_addr, exp_ra.pop_front());
        end
        if (rb_valid && rb_ready) begin
          log_rb.push_back(rb_data);
          rb_cnt++;
          last_rb_cyc = cyc;
          if (exp_rb.size() == 0) chk("rb_unexpected", 1, 0);
          else chk("rb_data", rb_data, exp_rb.pop_front());
        end
        if (err) err_cnt++;
        if (busy) busy_cyc++;
        if (busy_prev && !busy) busy_fall_cyc = cyc;
        busy_prev = busy;
      end else begin
        hold_pend = 1'b0;
        busy_prev = 1'b0;
      end
    end
  end

  // SDRAM read responder: R_BL words queued per accepted address.
  initial begin
    bit a_hs, d_hs;
    logic [23:0] ra;
    rd_valid = 1'b0;
    rd_data  = '0;
    forever begin
      @(negedge clk);
      a_hs = rst_n && rd_avalid && rd_aready;
      d_hs = rst_n && rd_valid && rd_ready;
      ra   = rd_addr;
      @(posedge clk);
      #1;
      if (!rst_n) resp_q.delete();
      else begin
        if (d_hs && resp_q.size() > 0) void'(resp_q.pop_front());
        if (a_hs) for (int k = 0; k < R_BL; k++) resp_q.push_back(mem_word(ra + 24'(k)));
      end
      rd_valid = (resp_q.size() > 0);
      rd_data  = (resp_q.size() > 0) ? resp_q[0] : 16'h0;
    end
  end

  // Backpressure patterns on the SDRAM side.
  initial begin
    wr_ready  = 1'b0;
    rd_aready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      wr_ready  = (cyc % 3) != 1;
      rd_aready = (cyc % 4) != 0;
    end
  end

  task automatic send_cmd(input bit wr, input logic [23:0] a, input logic [7:0] nb);
    bit ok;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_nburst = nb;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("cmd_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_bytes(input int n);
    bit ok;
    @(posedge clk);
    #1;
    for (int k = 0; k < n; k++) begin
      wb_valid = 1'b1;
      wb_data  = wbytes[k];
      ok = 1'b0;
      for (int t = 0; t < 100; t++) begin
        @(negedge clk);
        if (wb_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("wb_accept_timeout", 0, 1);
      @(posedge clk);
      #1;
    end
    wb_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int t = 0; t < n; t++) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_wa.delete(); log_wd.delete(); log_ra.delete(); log_rb.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {25'd0, busy, err, wb_ready, rb_valid, wr_valid, rd_avalid, rd_ready}, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_rb_data"}, rb_data, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_nburst = '0;
    wb_valid = 1'b0; wb_data = '0; rb_ready = 1'b1;

    // Reset state.
    idle_cycles(3);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk_reset_outputs("post_reset");

    // Write burst: bytes 01..08 at 0x10.
    clear_logs();
    for (int k = 0; k < 8; k++) wbytes[k] = 8'(k + 1);
    model_cmd(1'b1, 24'h000010, 1);
    send_cmd(1'b1, 24'h000010, 8'd1);
    send_bytes(8);
    wait_idle();
    chk("t1_nwords", log_wd.size(), 4);
    if (log_wd.size() == 4) begin
      chk("t1_wd0", log_wd[0], 16'h0201); chk("t1_wa0", log_wa[0], 32'h10);
      chk("t1_wd3", log_wd[3], 16'h0807); chk("t1_wa3", log_wa[3], 32'h16);
    end

    // Read two bursts from 0x20.
    clear_logs();
    model_cmd(1'b0, 24'h000020, 2);
    send_cmd(1'b0, 24'h000020, 8'd2);
    wait_idle();
    chk("t2_nra", log_ra.size(), 2);
    chk("t2_nrb", log_rb.size(), 16);
    if (log_ra.size() == 2) begin
      chk("t2_ra0", log_ra[0], 24'h10);
      chk("t2_ra1", log_ra[1], 24'h14);
    end
    if (log_rb.size() == 16) begin
      chk("t2_rb0", log_rb[0], 8'h10);
      chk("t2_rb1", log_rb[1], 8'h90);
      chk("t2_rb15", log_rb[15], 8'h97);
    end
    chk("t2_busy_fall", busy_fall_cyc - last_rb_cyc, 2);

    // Read with rb_ready stalled 5 cycles after the 3rd byte.
    begin
      int start;
      bit ok;
      clear_logs();
      model_cmd(1'b0, 24'h000040, 1);
      start = rb_cnt;
      send_cmd(1'b0, 24'h000040, 8'd1);
      ok = 1'b0;
      for (int t = 0; t < 200; t++) begin
        if (rb_cnt >= start + 3) begin ok = 1'b1; break; end
        @(posedge clk); #1;
      end
      if (!ok) chk("t3_wait_timeout", 0, 1);
      rb_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
        @(negedge clk);
        chk("t3_stall_valid", rb_valid, 1);
        chk("t3_stall_data", rb_data, (exp_rb.size() > 0) ? exp_rb[0] : 8'hxx);
        chk("t3_stall_rd_ready", rd_ready, 0);
      end
      @(posedge clk); #1;
      rb_ready = 1'b1;
      wait_idle();
      chk("t3_nrb", log_rb.size(), 8);
    end

    // Zero-burst command.
    busy_cyc = 0; traffic_cnt = 0;
    send_cmd(1'b1, 24'h000100, 8'd0);
    idle_cycles(8);
    chk("t4_busy_cycles", busy_cyc, 1);
    chk("t4_traffic", traffic_cnt, 0);

    // Misaligned address 0x000003.
    clear_logs();
    err_cnt = 0; traffic_cnt = 0;
    for (int k = 0; k < 8; k++) wbytes[k] = 8'(8'hA0 + k);
    model_cmd(1'b1, 24'h000003, 1);
    send_cmd(1'b1, 24'h000003, 8'd1);
`ifdef SDRAM_BRIDGE_ALIGN_CHK_EN
    idle_cycles(8);
    chk("t5_err_cycles", err_cnt, 1);
    chk("t5_traffic", traffic_cnt, 0);
    chk("t5_busy", busy, 0);
`else
    send_bytes(8);
    wait_idle();
    chk("t5_err_cycles", err_cnt, 0);
    chk("t5_nwords", log_wa.size(), 4);
    if (log_wa.size() > 0) begin
      chk("t5_wa0", log_wa[0], 32'h0);
      chk("t5_wd0", log_wd[0], 16'hA1A0);
    end
`endif

    // Reset after the 3rd write byte, then a fresh command.
    clear_logs();
    for (int k = 0; k < 8; k++) wbytes[k] = 8'(8'h31 + k);
    model_cmd(1'b1, 24'h000100, 1);
    send_cmd(1'b1, 24'h000100, 8'd1);
    send_bytes(3);
    rst_n = 1'b0;
    exp_wr.delete();
    @(negedge clk);
    chk_reset_outputs("t6_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_release_cmd_ready", cmd_ready, 1);
    chk("t6_release_wr_valid", wr_valid, 0);
    chk("t6_release_rd_avalid", rd_avalid, 0);
    clear_logs();
    for (int k = 0; k < 8; k++) wbytes[k] = 8'(8'h51 + k);
    model_cmd(1'b1, 24'h000200, 1);
    send_cmd(1'b1, 24'h000200, 8'd1);
    send_bytes(8);
    wait_idle();
    chk("t6_nwords", log_wa.size(), 4);
    if (log_wa.size() > 0) begin
      chk("t6_wa0", log_wa[0], 32'h200);
      chk("t6_wd0", log_wd[0], 16'h5251);
    end

    idle_cycles(2);
    chk("end_exp_wr_empty", exp_wr.size(), 0);
    chk("end_exp_ra_empty", exp_ra.size(), 0);
    chk("end_exp_rb_empty", exp_rb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_stream_bridge.md
SDRAM_STREAM_BRIDGE -- requirements
Module: sdram_stream_bridge

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock for all logic.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have ports cmd_valid (input, 1), cmd_ready (output, 1), cmd_wr (input, 1; 1=write, 0=read), cmd_addr (input, 24; byte address) and cmd_nburst (input, 8; burst count).
REQ-004 SHALL have ports wb_data (input, 8), wb_valid (input, 1) and wb_ready (output, 1): the write byte stream from QSPI.
REQ-005 SHALL have ports rb_data (output, 8), rb_valid (output, 1) and rb_ready (input, 1): the read byte stream to QSPI.
REQ-006 SHALL have ports wr_data (output, 16), wr_addr (output, 32; byte address), wr_valid (output, 1) and wr_ready (input, 1) toward the SDRAM data stage.
REQ-007 SHALL have ports rd_addr (output, 24; word address), rd_avalid (output, 1), rd_aready (input, 1), rd_data (input, 16), rd_valid (input, 1) and rd_ready (output, 1) toward the SDRAM data stage.
REQ-008 SHALL have ports busy (output, 1; a command is in progress) and err (output, 1; one-cycle pulse on a rejected command).

Function
REQ-009 SHALL use FSM states IDLE, WR_PACK, WR_PUSH, RD_ADDR, RD_DATA, RD_LO, RD_HI and DONE.
REQ-010 SHALL assert cmd_ready only in IDLE; on a cmd_valid&&cmd_ready cycle it SHALL latch addr, nburst and direction, then move to WR_PACK (write) or RD_ADDR (read).
REQ-011 SHALL treat cmd_nburst=0 as accepted with no SDRAM traffic: IDLE->DONE->IDLE.
REQ-012 SHALL define a burst as W_BL words (write) or R_BL words (read); a transfer is nburst*BL words, which is 2*nburst*BL bytes.
REQ-013 SHALL assert wb_ready only in WR_PACK; the first accepted byte fills word bits [7:0] and the second fills [15:8] (little-endian), and the second byte moves the FSM to WR_PUSH.
REQ-014 SHALL assert wr_valid only in WR_PUSH, with wr_addr = {8'd0, base + 2*word_idx}, and hold wr_data/wr_addr stable until wr_ready.
REQ-015 SHALL, on wr_valid&&wr_ready, increment word_idx and go to DONE after the last word, otherwise back to WR_PACK.
REQ-016 SHALL, in RD_ADDR, assert rd_avalid with rd_addr = (base>>1) + burst_idx*R_BL, and on rd_aready move to RD_DATA.
REQ-017 SHALL, in RD_DATA, assert rd_ready and capture rd_data on rd_valid, then go to RD_LO.
REQ-018 SHALL assert rb_valid in RD_LO (rb_data=word[7:0]) and in RD_HI (rb_data=word[15:8]), advancing on each rb_ready; rd_ready SHALL stay low during RD_LO and RD_HI so downstream stalls.
REQ-019 SHALL, after RD_HI: go to RD_DATA if the burst has more words; else to RD_ADDR with burst_idx+1 if bursts remain; else to DONE.
REQ-020 SHALL spend exactly one cycle in DONE with busy=1, then return to IDLE; busy SHALL be 0 only in IDLE.
REQ-021 SHALL wrap address arithmetic modulo 2^24 with no error.
REQ-022 SHALL ignore wb_valid, rd_valid and rb_ready while in states where the matching ready/valid output is low.

Reset
REQ-023 SHALL, on rst_n low, force state to IDLE, discard partial packed or unpacked data, and clear counters to 0.
REQ-024 SHALL reset outputs to: cmd_ready=1 once rst_n is released; busy, err, wb_ready, rb_valid, wr_valid, rd_avalid and rd_ready=0; all data and address outputs=0.
REQ-025 SHALL, on reset mid-transfer, leave no pending wr_valid or rd_avalid in the first cycle after release.

Configuration
REQ-026 SHALL define macro SDRAM_BRIDGE_ALIGN_CHK_EN; when defined, a command whose cmd_addr is not aligned to 2*BL bytes SHALL be accepted, pulse err for one cycle, cause no traffic, and return to IDLE via DONE.
REQ-027 SHALL, without SDRAM_BRIDGE_ALIGN_CHK_EN, clear the low log2(2*BL) address bits on latch and tie err to 0.

Structure
REQ-028 SHALL take W_BL, R_BL and the FSM state encodings from the shared package sdram_param, which holds the bridge states alongside the existing data-stage states.
REQ-029 SHALL be implemented as a single module with no sub-module; the packer and unpacker are inline registers.

Verification
REQ-030 Bench SHALL cover: write cmd addr=0x000010, nburst=1, W_BL=4, bytes 01..08 -> wr_data 0x0201, 0x0403, 0x0605, 0x0807 at wr_addr 0x10, 0x12, 0x14, 0x16.
REQ-031 Bench SHALL cover: read cmd addr=0x000020, nburst=2, R_BL=4 -> rd_addr 0x10 then 0x14, 16 bytes out in LE order, busy deasserts one cycle after the last rb handshake.
REQ-032 Bench SHALL cover: rb_ready held low 5 cycles mid-read -> rb_data stable, rd_ready=0 throughout, no byte lost.
REQ-033 Bench SHALL cover: cmd_nburst=0 -> busy high exactly 1 cycle, no wr_valid or rd_avalid.
REQ-034 Bench SHALL cover: with macro defined, addr=0x000003 -> err pulse of 1 cycle and no traffic; without the macro, traffic starts at byte 0x000000.
REQ-035 Bench SHALL cover: rst_n asserted after the 3rd write byte -> all outputs at reset values, and the next command starts at word_idx=0.
